// File: rtl/tdp_ram_bwe_if.sv
// tdp_ram_bwe_if: both access ports of the dual-port RAM plus the
// collision flag, with master (requester) and slave (memory) views.
interface tdp_ram_bwe_if #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 8
);
  localparam int NB = DATA_W / BYTE_W;

  logic              enA;
  logic [NB-1:0]     weA;
  logic [ADDR_W-1:0] addrA;
  logic [DATA_W-1:0] dinA;
  logic [DATA_W-1:0] doutA;
  logic              validA;

  logic              enB;
  logic [NB-1:0]     weB;
  logic [ADDR_W-1:0] addrB;
  logic [DATA_W-1:0] dinB;
  logic [DATA_W-1:0] doutB;
  logic              validB;

  logic              collision;

  modport master (
    output enA, weA, addrA, dinA,
    output enB, weB, addrB, dinB,
    input  doutA, validA, doutB, validB,
    input  collision
  );

  modport slave (
    input  enA, weA, addrA, dinA,
    input  enB, weB, addrB, dinB,
    output doutA, validA, doutB, validB,
    output collision
  );
endinterface

// File: rtl/tdp_ram_bwe.sv
// tdp_ram_bwe: single-clock true dual-port RAM with byte enables,
// per-port read-during-write mode, optional output stage, zero-clear.
module tdp_ram_bwe #(
  parameter int DATA_W         = 32,
  parameter int BYTE_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int WRITE_MODE_A   = 0,
  parameter int WRITE_MODE_B   = 0,
  parameter bit OUT_REG        = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         init_done_o,
  tdp_ram_bwe_if.slave bus
);
  localparam int NB = DATA_W / BYTE_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   ptr_q;
  logic            init_done_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              en     [2];
  logic [NB-1:0]     we     [2];
  logic [ADDR_W-1:0] addr   [2];
  logic [DATA_W-1:0] din    [2];
  logic              acc    [2];
  logic              inr    [2];
  logic [AW-1:0]     idx    [2];
  logic [DATA_W-1:0] old    [2];
  logic [DATA_W-1:0] mrg    [2];
  logic [NB-1:0]     wl_raw [2];
  logic [DATA_W-1:0] rdat_d [2];
  logic              pulse_d[2];

  logic [DATA_W-1:0] rd1_q  [2];
  logic [DATA_W-1:0] rd2_q  [2];
  logic              v1_q   [2];
  logic              v2_q   [2];

  logic [NB-1:0] wl_a;
  logic [NB-1:0] wl_b;
  logic          same_addr;
  logic          col_d;
  logic          col1_q;
  logic          col2_q;
  logic          clr_we;

  function automatic int mode_of(input int p);
    return (p == 0) ? WRITE_MODE_A : WRITE_MODE_B;
  endfunction

  assign en[0]   = bus.enA;
  assign we[0]   = bus.weA;
  assign addr[0] = bus.addrA;
  assign din[0]  = bus.dinA;
  assign en[1]   = bus.enB;
  assign we[1]   = bus.weB;
  assign addr[1] = bus.addrB;
  assign din[1]  = bus.dinB;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      acc[p]     = init_done_q & en[p];
      inr[p]     = {1'b0, addr[p]} < DEPTH_L;
      idx[p]     = addr[p][AW-1:0];
      old[p]     = inr[p] ? mem[idx[p]] : '0;
      mrg[p]     = old[p];
      wl_raw[p]  = '0;
      for (int b = 0; b < NB; b++) begin
        if (we[p][b]) begin
          mrg[p][b*BYTE_W +: BYTE_W] = din[p][b*BYTE_W +: BYTE_W];
        end
        wl_raw[p][b] = acc[p] & inr[p] & we[p][b];
      end
      pulse_d[p] = acc[p];
      rdat_d[p]  = old[p];
      // reads always see the pre-edge word; only the own port may merge
      if (inr[p] && (|we[p])) begin
        if (mode_of(p) == 0) begin
          rdat_d[p] = mrg[p];
        end else if (mode_of(p) == 2) begin
          pulse_d[p] = 1'b0;
        end
      end
    end
  end

  assign same_addr = (addr[0] == addr[1]);
  assign wl_a      = wl_raw[0];
  assign wl_b      = wl_raw[1] & ~(wl_raw[0] & {NB{same_addr}});
  assign col_d     = acc[0] & acc[1] & inr[0] & inr[1] & same_addr
                   & ((|we[0]) | (|we[1]));
  assign clr_we    = rst_n & (state_q == S_CLEAR);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr_q] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (wl_a[b]) mem[idx[0]][b*BYTE_W +: BYTE_W] <= din[0][b*BYTE_W +: BYTE_W];
        if (wl_b[b]) mem[idx[1]][b*BYTE_W +: BYTE_W] <= din[1][b*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      col1_q      <= 1'b0;
      col2_q      <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        rd1_q[p] <= '0;
        rd2_q[p] <= '0;
        v1_q[p]  <= 1'b0;
        v2_q[p]  <= 1'b0;
      end
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          if (ptr_q == LAST) state_q <= S_READY;
          else               ptr_q   <= ptr_q + 1'b1;
        end
        S_READY: init_done_q <= 1'b1;
        default: state_q <= S_READY;
      endcase
      col1_q <= col_d;
      col2_q <= col1_q;
      for (int p = 0; p < 2; p++) begin
        v1_q[p] <= pulse_d[p];
        if (pulse_d[p]) rd1_q[p] <= rdat_d[p];
        v2_q[p] <= v1_q[p];
        if (v1_q[p]) rd2_q[p] <= rd1_q[p];
      end
    end
  end

  assign init_done_o   = init_done_q;
  assign bus.doutA     = OUT_REG ? rd2_q[0] : rd1_q[0];
  assign bus.doutB     = OUT_REG ? rd2_q[1] : rd1_q[1];
  assign bus.validA    = OUT_REG ? v2_q[0]  : v1_q[0];
  assign bus.validB    = OUT_REG ? v2_q[1]  : v1_q[1];
  assign bus.collision = OUT_REG ? col2_q   : col1_q;

endmodule

// File: tb/tb_tdp_ram_bwe.sv
// tb_tdp_ram_bwe: directed checks of clear FSM, latency, byte enables,
// read-during-write modes, collisions and out-of-range accesses.
module tb_tdp_ram_bwe;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  logic done_a, done_b, done_c;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tdp_ram_bwe_if #(.DATA_W(32), .BYTE_W(8), .ADDR_W(8)) bus_a ();
  tdp_ram_bwe_if #(.DATA_W(32), .BYTE_W(8), .ADDR_W(8)) bus_b ();
  tdp_ram_bwe_if #(.DATA_W(32), .BYTE_W(8), .ADDR_W(8)) bus_c ();

  // a: DEPTH 16, latency 2, A write-first, B read-first
  tdp_ram_bwe #(
    .DATA_W(32), .BYTE_W(8), .ADDR_W(8), .DEPTH(16),
    .WRITE_MODE_A(0), .WRITE_MODE_B(1),
    .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1)
  ) u_a (.clk(clk), .rst_n(rst_a), .init_done_o(done_a), .bus(bus_a));

  // b: DEPTH 200, latency 1, A no-change, B write-first
  tdp_ram_bwe #(
    .DATA_W(32), .BYTE_W(8), .ADDR_W(8), .DEPTH(200),
    .WRITE_MODE_A(2), .WRITE_MODE_B(0),
    .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1)
  ) u_b (.clk(clk), .rst_n(rst_b), .init_done_o(done_b), .bus(bus_b));

  // c: no clear after reset
  tdp_ram_bwe #(
    .DATA_W(32), .BYTE_W(8), .ADDR_W(8), .DEPTH(16),
    .WRITE_MODE_A(0), .WRITE_MODE_B(0),
    .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b0)
  ) u_c (.clk(clk), .rst_n(rst_c), .init_done_o(done_c), .bus(bus_c));

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv_a(
    input logic ea, input logic [3:0] wa, input logic [7:0] aa, input logic [31:0] da,
    input logic eb, input logic [3:0] wb, input logic [7:0] ab, input logic [31:0] db
  );
    bus_a.enA = ea; bus_a.weA = wa; bus_a.addrA = aa; bus_a.dinA = da;
    bus_a.enB = eb; bus_a.weB = wb; bus_a.addrB = ab; bus_a.dinB = db;
  endtask

  task automatic drv_b(
    input logic ea, input logic [3:0] wa, input logic [7:0] aa, input logic [31:0] da,
    input logic eb, input logic [3:0] wb, input logic [7:0] ab, input logic [31:0] db
  );
    bus_b.enA = ea; bus_b.weA = wa; bus_b.addrA = aa; bus_b.dinA = da;
    bus_b.enB = eb; bus_b.weB = wb; bus_b.addrB = ab; bus_b.dinB = db;
  endtask

  task automatic idle_a;
    drv_a(1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
  endtask

  task automatic idle_b;
    drv_b(1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
  endtask

  task automatic test_reset;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    idle_a; idle_b;
    bus_c.enA = 1'b0; bus_c.weA = 4'h0; bus_c.addrA = 8'h0; bus_c.dinA = 32'h0;
    bus_c.enB = 1'b0; bus_c.weB = 4'h0; bus_c.addrB = 8'h0; bus_c.dinB = 32'h0;
    tick; tick;
    checks++;
    if (done_a !== 1'b0) begin failures++; $display("FAIL rst_done_a got=%b exp=0", done_a); end
    checks++;
    if (done_b !== 1'b0) begin failures++; $display("FAIL rst_done_b got=%b exp=0", done_b); end
    checks++;
    if (done_c !== 1'b0) begin failures++; $display("FAIL rst_done_c got=%b exp=0", done_c); end
    checks++;
    if (bus_a.validA !== 1'b0) begin failures++; $display("FAIL rst_validA got=%b exp=0", bus_a.validA); end
    checks++;
    if (bus_a.doutA !== 32'h0) begin failures++; $display("FAIL rst_doutA got=%h exp=0", bus_a.doutA); end
    checks++;
    if (bus_a.collision !== 1'b0) begin failures++; $display("FAIL rst_coll got=%b exp=0", bus_a.collision); end
    checks++;
    if (bus_b.doutB !== 32'h0) begin failures++; $display("FAIL rst_doutB_b got=%h exp=0", bus_b.doutB); end
  endtask

  task automatic test_clear;
    bit sawv;
    sawv = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    drv_b(1'b1, 4'hF, 8'd190, 32'hCAFEF00D, 1'b1, 4'h0, 8'd190, 32'h0);
    for (int n = 1; n <= 201; n++) begin
      tick;
      if (bus_b.validA || bus_b.validB) sawv = 1'b1;
      if (n == 19) idle_b;
      if (n == 1) begin
        checks++;
        if (done_c !== 1'b1) begin failures++; $display("FAIL noclr_done got=%b exp=1", done_c); end
      end
      if (n == 16) begin
        checks++;
        if (done_a !== 1'b0) begin failures++; $display("FAIL clr16_done_a got=%b exp=0", done_a); end
      end
      if (n == 17) begin
        checks++;
        if (done_a !== 1'b1) begin failures++; $display("FAIL clr17_done_a got=%b exp=1", done_a); end
      end
      if (n == 200) begin
        checks++;
        if (done_b !== 1'b0) begin failures++; $display("FAIL clr200_done_b got=%b exp=0", done_b); end
      end
      if (n == 201) begin
        checks++;
        if (done_b !== 1'b1) begin failures++; $display("FAIL clr201_done_b got=%b exp=1", done_b); end
      end
    end
    checks++;
    if (sawv !== 1'b0) begin failures++; $display("FAIL clr_no_valid got=%b exp=0", sawv); end
  endtask

  task automatic test_latency;
    drv_a(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 4'hF, 8'd5, 32'hDEADBEEF);
    tick; idle_a; tick; tick;
    drv_a(1'b1, 4'h0, 8'd5, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0);
    tick;
    checks++;
    if (bus_a.validA !== 1'b0) begin failures++; $display("FAIL lat2_early got=%b exp=0", bus_a.validA); end
    idle_a; tick;
    checks++;
    if (bus_a.validA !== 1'b1) begin failures++; $display("FAIL lat2_valid got=%b exp=1", bus_a.validA); end
    checks++;
    if (bus_a.doutA !== 32'hDEADBEEF) begin failures++; $display("FAIL lat2_dout got=%h exp=deadbeef", bus_a.doutA); end
    tick;
    checks++;
    if (bus_a.validA !== 1'b0) begin failures++; $display("FAIL lat2_pulse got=%b exp=0", bus_a.validA); end
    checks++;
    if (bus_a.doutA !== 32'hDEADBEEF) begin failures++; $display("FAIL lat2_hold got=%h exp=deadbeef", bus_a.doutA); end
    drv_b(1'b1, 4'hF, 8'd5, 32'hDEADBEEF, 1'b0, 4'h0, 8'd0, 32'h0);
    tick;
    checks++;
    if (bus_b.validA !== 1'b0) begin failures++; $display("FAIL nc_wr_valid got=%b exp=0", bus_b.validA); end
    idle_b; tick;
    drv_b(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 4'h0, 8'd5, 32'h0);
    tick;
    checks++;
    if (bus_b.validB !== 1'b1) begin failures++; $display("FAIL lat1_valid got=%b exp=1", bus_b.validB); end
    checks++;
    if (bus_b.doutB !== 32'hDEADBEEF) begin failures++; $display("FAIL lat1_dout got=%h exp=deadbeef", bus_b.doutB); end
    idle_b; tick;
    checks++;
    if (bus_b.validB !== 1'b0) begin failures++; $display("FAIL lat1_pulse got=%b exp=0", bus_b.validB); end
  endtask

  task automatic test_byte_enables;
    drv_a(1'b1, 4'hF, 8'd3, 32'h11223344, 1'b0, 4'h0, 8'd0, 32'h0);
    tick;
    drv_a(1'b1, 4'b0101, 8'd3, 32'hAABBCCDD, 1'b0, 4'h0, 8'd0, 32'h0);
    tick; idle_a; tick;
    checks++;
    if (bus_a.doutA !== 32'h11BB33DD) begin failures++; $display("FAIL be_wf_merge got=%h exp=11bb33dd", bus_a.doutA); end
    tick;
    drv_a(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 4'h0, 8'd3, 32'h0);
    tick; idle_a; tick;
    checks++;
    if (bus_a.doutB !== 32'h11BB33DD) begin failures++; $display("FAIL be_read got=%h exp=11bb33dd", bus_a.doutB); end
    tick;
    // 19 would alias onto word 3 if the range check were missing
    drv_a(1'b1, 4'hF, 8'd19, 32'hFFFFFFFF, 1'b0, 4'h0, 8'd0, 32'h0);
    tick; idle_a; tick;
    checks++;
    if (bus_a.validA !== 1'b1 || bus_a.doutA !== 32'h0) begin
      failures++; $display("FAIL oob_wr_read got=%h/%b exp=0/1", bus_a.doutA, bus_a.validA);
    end
    tick;
    drv_a(1'b1, 4'h0, 8'd3, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0);
    tick; idle_a; tick;
    checks++;
    if (bus_a.doutA !== 32'h11BB33DD) begin failures++; $display("FAIL oob_no_alias got=%h exp=11bb33dd", bus_a.doutA); end
    tick;
  endtask

  task automatic test_rdw_modes;
    drv_a(1'b1, 4'hF, 8'd9, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0);
    tick; idle_a; tick; tick;
    drv_a(1'b1, 4'hF, 8'd9, 32'h55, 1'b0, 4'h0, 8'd0, 32'h0);
    tick; idle_a; tick;
    checks++;
    if (bus_a.doutA !== 32'h55 || bus_a.validA !== 1'b1) begin
      failures++; $display("FAIL wf_dout got=%h/%b exp=55/1", bus_a.doutA, bus_a.validA);
    end
    tick;
    drv_a(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 4'hF, 8'd10, 32'h55);
    tick; idle_a; tick;
    checks++;
    if (bus_a.doutB !== 32'h0 || bus_a.validB !== 1'b1) begin
      failures++; $display("FAIL rf_dout got=%h/%b exp=0/1", bus_a.doutB, bus_a.validB);
    end
    tick;
    drv_a(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 4'h0, 8'd10, 32'h0);
    tick; idle_a; tick;
    checks++;
    if (bus_a.doutB !== 32'h55) begin failures++; $display("FAIL rf_after got=%h exp=55", bus_a.doutB); end
    tick;
    drv_b(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 4'hF, 8'd8, 32'h1234);
    tick; idle_b; tick;
    drv_b(1'b1, 4'h0, 8'd8, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0);
    tick;
    checks++;
    if (bus_b.doutA !== 32'h1234) begin failures++; $display("FAIL nc_prior got=%h exp=1234", bus_b.doutA); end
    drv_b(1'b1, 4'hF, 8'd9, 32'h55, 1'b0, 4'h0, 8'd0, 32'h0);
    tick;
    checks++;
    if (bus_b.validA !== 1'b0 || bus_b.doutA !== 32'h1234) begin
      failures++; $display("FAIL nc_keep got=%h/%b exp=1234/0", bus_b.doutA, bus_b.validA);
    end
    drv_b(1'b1, 4'h0, 8'd9, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0);
    tick;
    checks++;
    if (bus_b.doutA !== 32'h55 || bus_b.validA !== 1'b1) begin
      failures++; $display("FAIL nc_after got=%h/%b exp=55/1", bus_b.doutA, bus_b.validA);
    end
    idle_b; tick;
  endtask

  task automatic test_collision;
    drv_b(1'b1, 4'b0011, 8'd20, 32'h11111111, 1'b1, 4'hF, 8'd20, 32'h22222222);
    tick;
    checks++;
    if (bus_b.collision !== 1'b1) begin failures++; $display("FAIL coll_ww got=%b exp=1", bus_b.collision); end
    checks++;
    if (bus_b.doutB !== 32'h22222222) begin failures++; $display("FAIL coll_wf_b got=%h exp=22222222", bus_b.doutB); end
    idle_b; tick;
    checks++;
    if (bus_b.collision !== 1'b0) begin failures++; $display("FAIL coll_pulse got=%b exp=0", bus_b.collision); end
    drv_b(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 4'h0, 8'd20, 32'h0);
    tick;
    checks++;
    if (bus_b.doutB !== 32'h22221111) begin failures++; $display("FAIL coll_word got=%h exp=22221111", bus_b.doutB); end
    drv_b(1'b1, 4'hF, 8'd20, 32'h33333333, 1'b1, 4'h0, 8'd20, 32'h0);
    tick;
    checks++;
    if (bus_b.doutB !== 32'h22221111 || bus_b.collision !== 1'b1) begin
      failures++; $display("FAIL coll_rw_old got=%h/%b exp=22221111/1", bus_b.doutB, bus_b.collision);
    end
    drv_b(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 4'h0, 8'd20, 32'h0);
    tick;
    checks++;
    if (bus_b.doutB !== 32'h33333333) begin failures++; $display("FAIL coll_rw_new got=%h exp=33333333", bus_b.doutB); end
    drv_b(1'b1, 4'hF, 8'd21, 32'h44, 1'b1, 4'h0, 8'd22, 32'h0);
    tick;
    checks++;
    if (bus_b.collision !== 1'b0) begin failures++; $display("FAIL coll_diff got=%b exp=0", bus_b.collision); end
    drv_b(1'b1, 4'hF, 8'd250, 32'h44, 1'b1, 4'h0, 8'd250, 32'h0);
    tick;
    checks++;
    if (bus_b.collision !== 1'b0 || bus_b.doutB !== 32'h0) begin
      failures++; $display("FAIL coll_oob got=%b/%h exp=0/0", bus_b.collision, bus_b.doutB);
    end
    idle_b; tick;
  endtask

  task automatic test_out_of_range;
    drv_b(1'b1, 4'h0, 8'd250, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0);
    tick;
    checks++;
    if (bus_b.doutA !== 32'h0 || bus_b.validA !== 1'b1) begin
      failures++; $display("FAIL oob_read got=%h/%b exp=0/1", bus_b.doutA, bus_b.validA);
    end
    idle_b; tick;
  endtask

  task automatic test_clear_restart;
    logic [31:0] acc;
    int          nv;
    acc = 32'h0;
    nv  = 0;
    for (int i = 0; i < 16; i++) begin
      drv_a(1'b1, 4'hF, 8'(i), 32'hA5A50000 | 32'(i), 1'b0, 4'h0, 8'd0, 32'h0);
      tick;
    end
    idle_a; tick; tick;
    rst_a = 1'b0;
    tick;
    checks++;
    if (done_a !== 1'b0 || bus_a.validA !== 1'b0) begin
      failures++; $display("FAIL rst_drop got=%b/%b exp=0/0", done_a, bus_a.validA);
    end
    rst_a = 1'b1;
    for (int n = 0; n < 7; n++) tick;
    rst_a = 1'b0;
    tick;
    checks++;
    if (done_a !== 1'b0) begin failures++; $display("FAIL midclr_rst got=%b exp=0", done_a); end
    rst_a = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      tick;
      if (n == 16) begin
        checks++;
        if (done_a !== 1'b0) begin failures++; $display("FAIL restart16 got=%b exp=0", done_a); end
      end
      if (n == 17) begin
        checks++;
        if (done_a !== 1'b1) begin failures++; $display("FAIL restart17 got=%b exp=1", done_a); end
      end
    end
    for (int i = 0; i < 16; i++) begin
      drv_a(1'b1, 4'h0, 8'(i), 32'h0, 1'b0, 4'h0, 8'd0, 32'h0);
      tick; idle_a; tick;
      acc = acc | bus_a.doutA;
      if (bus_a.validA === 1'b1) nv++;
    end
    checks++;
    if (acc !== 32'h0 || nv != 16) begin
      failures++; $display("FAIL clear_zero got=%h/%0d exp=0/16", acc, nv);
    end
  endtask

  initial begin
    test_reset;
    test_clear;
    test_latency;
    test_byte_enables;
    test_rdw_modes;
    test_collision;
    test_out_of_range;
    test_clear_restart;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
